// File: rtl/intr_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : intr_ctrl_pkg
// Brief    : FSM encodings and register-map offsets shared by the interrupt
//            controller top and its arbiter.
// Revision : 2.0
// ============================================================================
package intr_ctrl_pkg;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE = 3'b001;
    localparam state_t S_ARB  = 3'b010;
    localparam state_t S_WAIT = 3'b100;

    // PRIO[n] lives at word n; the control words follow the PRIO block.
    function automatic int prio_off(input int idx);
        return idx;
    endfunction

    function automatic int mask_off(input int num_per);
        return num_per;
    endfunction

    function automatic int pend_off(input int num_per);
        return num_per + 1;
    endfunction

    function automatic int mode_off(input int num_per);
        return num_per + 2;
    endfunction

    function automatic int map_size(input int num_per);
        return num_per + 3;
    endfunction

endpackage
`default_nettype wire

// File: rtl/intr_pri_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : intr_pri_arbiter
// Brief    : Combinational max-priority select; ties go to the lowest index.
// Revision : 2.0
// ============================================================================
module intr_pri_arbiter #(
    parameter int NUM_PER = 16,
    parameter int PRI_W   = 4,
    parameter int ID_W    = $clog2(NUM_PER)
) (
    input  logic [NUM_PER-1:0]       i_eligible,
    input  logic [NUM_PER*PRI_W-1:0] i_prio_flat,
    output logic [ID_W-1:0]          o_winner_id,
    output logic                     o_any_valid
);

    logic [PRI_W-1:0] w_best_pri;
    logic [ID_W-1:0]  w_winner;

    // Strict '>' while scanning upward keeps the lowest index on a tie.
    always_comb begin
        w_best_pri = '0;
        w_winner   = '0;
        for (int n = 0; n < NUM_PER; n++) begin
            if (i_eligible[n] && (i_prio_flat[n*PRI_W +: PRI_W] > w_best_pri)) begin
                w_best_pri = i_prio_flat[n*PRI_W +: PRI_W];
                w_winner   = ID_W'(n);
            end
        end
    end

    assign o_winner_id = w_winner;
    assign o_any_valid = |i_eligible;

endmodule
`default_nettype wire

// File: rtl/apb_intr_ctrl_v2.sv
`default_nettype none
// ============================================================================
// Module   : apb_intr_ctrl_v2
// Brief    : APB-programmable interrupt controller (PRIO/MASK/PEND/MODE) with
//            a registered valid/ack handshake. INTR_EDGE_DETECT_EN enables
//            per-source edge mode and W1C on PEND.
// Revision : 2.0
// ============================================================================
module apb_intr_ctrl_v2
    import intr_ctrl_pkg::*;
#(
    parameter int NUM_PER = 16,
    parameter int PRI_W   = 4,
    parameter int ADDR_W  = $clog2(NUM_PER + 3),
    parameter int DATA_W  = NUM_PER,
    parameter int ID_W    = $clog2(NUM_PER)
) (
    input  logic              pclk_i,
    input  logic              prst_i,
    input  logic              psel_i,
    input  logic              penable_i,
    input  logic              pwrite_i,
    input  logic [ADDR_W-1:0] paddr_i,
    input  logic [DATA_W-1:0] pwdata_i,
    output logic [DATA_W-1:0] prdata_o,
    output logic              pready_o,
    output logic              pslverr_o,
    input  logic [NUM_PER-1:0] int_active_i,
    output logic              intr_valid_o,
    output logic [ID_W-1:0]   intr_id_o,
    input  logic              intr_ack_i
);

    logic [PRI_W-1:0]         r_prio [NUM_PER];
    logic [NUM_PER-1:0]       r_mask;
    logic [DATA_W-1:0]        r_prdata;
    state_t                   r_state;
    logic                     r_intr_valid;
    logic [ID_W-1:0]          r_intr_id;

    logic [31:0]              w_addr;
    logic                     w_acc;
    logic                     w_in_map;
    logic                     w_wr;
    logic [DATA_W-1:0]        w_rdata;
    logic [NUM_PER-1:0]       w_pend;
    logic [NUM_PER-1:0]       w_mode_rd;
    logic [NUM_PER-1:0]       w_prio_nz;
    logic [NUM_PER-1:0]       w_eligible;
    logic [NUM_PER*PRI_W-1:0] w_prio_flat;
    logic [ID_W-1:0]          w_winner;
    logic                     w_any;

    assign w_addr   = 32'(paddr_i);
    assign w_acc    = psel_i & penable_i;
    assign w_in_map = (w_addr < 32'(map_size(NUM_PER)));
    assign w_wr     = w_acc & pwrite_i & w_in_map;

    assign pready_o  = w_acc & ~prst_i;
    assign pslverr_o = w_acc & ~prst_i & ~w_in_map;

    // ---------------- pending / edge logic ----------------
`ifdef INTR_EDGE_DETECT_EN
    logic [NUM_PER-1:0] r_mode;
    logic [NUM_PER-1:0] r_prev;
    logic [NUM_PER-1:0] r_pend_edge;
    logic [NUM_PER-1:0] w_rise;
    logic [NUM_PER-1:0] w_clr;

    assign w_rise = int_active_i & ~r_prev & r_mode;

    always_comb begin
        w_clr = '0;
        if (w_wr && (w_addr == 32'(pend_off(NUM_PER)))) begin
            w_clr = pwdata_i[NUM_PER-1:0];
        end
        if ((r_state == S_WAIT) && intr_ack_i) begin
            w_clr = w_clr | (NUM_PER'(1) << r_intr_id);
        end
    end

    // A new edge overrides any clear landing on the same cycle.
    always_ff @(posedge pclk_i) begin
        if (prst_i) begin
            r_mode      <= '0;
            r_prev      <= '0;
            r_pend_edge <= '0;
        end else begin
            r_prev      <= int_active_i;
            r_pend_edge <= r_mode & ((r_pend_edge & ~w_clr) | w_rise);
            if (w_wr && (w_addr == 32'(mode_off(NUM_PER)))) begin
                r_mode <= pwdata_i[NUM_PER-1:0];
            end
        end
    end

    assign w_pend    = (r_mode & r_pend_edge) | (~r_mode & int_active_i);
    assign w_mode_rd = r_mode;
`else
    assign w_pend    = int_active_i;
    assign w_mode_rd = '0;
`endif

    // ---------------- register file ----------------
    always_ff @(posedge pclk_i) begin
        if (prst_i) begin
            for (int n = 0; n < NUM_PER; n++) begin
                r_prio[n] <= '0;
            end
            r_mask <= '0;
        end else if (w_wr) begin
            for (int n = 0; n < NUM_PER; n++) begin
                if (w_addr == 32'(prio_off(n))) begin
                    r_prio[n] <= pwdata_i[PRI_W-1:0];
                end
            end
            if (w_addr == 32'(mask_off(NUM_PER))) begin
                r_mask <= pwdata_i[NUM_PER-1:0];
            end
        end
    end

    // Out-of-map words decode to zero, which doubles as the error read value.
    always_comb begin
        w_rdata = '0;
        for (int n = 0; n < NUM_PER; n++) begin
            if (w_addr == 32'(prio_off(n))) begin
                w_rdata = DATA_W'(r_prio[n]);
            end
        end
        if (w_addr == 32'(mask_off(NUM_PER))) w_rdata = DATA_W'(r_mask);
        if (w_addr == 32'(pend_off(NUM_PER))) w_rdata = DATA_W'(w_pend);
        if (w_addr == 32'(mode_off(NUM_PER))) w_rdata = DATA_W'(w_mode_rd);
    end

    always_ff @(posedge pclk_i) begin
        if (prst_i) begin
            r_prdata <= '0;
        end else if (w_acc && (!pwrite_i || !w_in_map)) begin
            r_prdata <= w_rdata;
        end
    end

    assign prdata_o = r_prdata;

    // ---------------- arbitration ----------------
    for (genvar g = 0; g < NUM_PER; g++) begin : g_src
        assign w_prio_flat[g*PRI_W +: PRI_W] = r_prio[g];
        assign w_prio_nz[g]                  = |r_prio[g];
    end

    assign w_eligible = w_pend & r_mask & w_prio_nz;

    intr_pri_arbiter #(
        .NUM_PER (NUM_PER),
        .PRI_W   (PRI_W),
        .ID_W    (ID_W)
    ) u_arb (
        .i_eligible  (w_eligible),
        .i_prio_flat (w_prio_flat),
        .o_winner_id (w_winner),
        .o_any_valid (w_any)
    );

    // ---------------- processor handshake FSM ----------------
    always_ff @(posedge pclk_i) begin
        if (prst_i) begin
            r_state      <= S_IDLE;
            r_intr_valid <= 1'b0;
            r_intr_id    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) r_state <= S_ARB;
                end
                S_ARB: begin
                    if (w_any) begin
                        r_intr_id    <= w_winner;
                        r_intr_valid <= 1'b1;
                        r_state      <= S_WAIT;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (intr_ack_i) begin
                        r_intr_valid <= 1'b0;
                        r_state      <= S_IDLE;
                    end
                end
                default: begin
                    r_intr_valid <= 1'b0;
                    r_state      <= S_IDLE;
                end
            endcase
        end
    end

    assign intr_valid_o = r_intr_valid;
    assign intr_id_o    = r_intr_id;

endmodule
`default_nettype wire
